// File: rtl/npc_seq_ctrl.sv
// Multi-cycle sequencer for the single-issue RV32 core: owns PC and the latched instruction,
// runs fetch, steps the LSU, gates the register-file write and halts on faults or timeouts.
module npc_seq_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int          TIMEOUT   = 256,
  parameter int          INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ifu_req,
  output logic [31:0]          ifu_addr,
  input  logic                 ifu_gnt,
  input  logic                 ifu_rvalid,
  input  logic [31:0]          ifu_rdata,
  output logic [31:0]          pc,
  output logic [31:0]          inst,
  input  logic [31:0]          dec_dnpc,
  input  logic [2:0]           dec_load,
  input  logic [3:0]           dec_store,
  input  logic                 dec_regW,
  input  logic                 dec_ebreak,
  input  logic                 dec_inv,
  output logic                 lsu_req,
  input  logic                 lsu_done,
  output logic                 wb_en,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halt,
  output logic [1:0]           halt_code
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, FWAIT, DECODE, MEM, WB, HALT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // The counter sits at TIMEOUT-1 during the last allowed wait cycle; a completion then still wins.
  assign tmo_hit  = (tmo_cnt == CNT_LAST);
  assign ifu_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inst      <= 32'h0000_0013;
      instret   <= '0;
      halt      <= 1'b0;
      halt_code <= 2'd0;
      ifu_req   <= 1'b0;
      lsu_req   <= 1'b0;
      wb_en     <= 1'b0;
      retire    <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      wb_en  <= 1'b0;
      retire <= 1'b0;
      case (state)
        IDLE: begin
          state   <= FETCH;
          ifu_req <= 1'b1;
          tmo_cnt <= '0;
        end
        FETCH: begin
          if (ifu_gnt) begin
            ifu_req <= 1'b0;
            tmo_cnt <= '0;
            if (ifu_rvalid) begin
              inst  <= ifu_rdata;
              state <= DECODE;
            end else begin
              state <= FWAIT;
            end
          end else if (tmo_hit) begin
            ifu_req   <= 1'b0;
            state     <= HALT;
            halt      <= 1'b1;
            halt_code <= 2'd3;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        FWAIT: begin
          if (ifu_rvalid) begin
            inst  <= ifu_rdata;
            state <= DECODE;
          end else if (tmo_hit) begin
            state     <= HALT;
            halt      <= 1'b1;
            halt_code <= 2'd3;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        // Fault priority: ebreak, then illegal encoding, then a misaligned next PC.
        DECODE: begin
          if (dec_ebreak) begin
            state     <= HALT;
            halt      <= 1'b1;
            halt_code <= 2'd1;
          end else if (dec_inv || (dec_dnpc[1:0] != 2'b00)) begin
            state     <= HALT;
            halt      <= 1'b1;
            halt_code <= 2'd2;
          end else if ((dec_load != 3'd0) || (dec_store != 4'd0)) begin
            state   <= MEM;
            lsu_req <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            state  <= WB;
            wb_en  <= dec_regW;
            retire <= 1'b1;
          end
        end
        MEM: begin
          if (lsu_done) begin
            lsu_req <= 1'b0;
            state   <= WB;
            wb_en   <= dec_regW;
            retire  <= 1'b1;
          end else if (tmo_hit) begin
            lsu_req   <= 1'b0;
            state     <= HALT;
            halt      <= 1'b1;
            halt_code <= 2'd3;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        WB: begin
          pc      <= dec_dnpc;
          instret <= instret + INSTRET_W'(1);
          state   <= FETCH;
          ifu_req <= 1'b1;
          tmo_cnt <= '0;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed bench for npc_seq_ctrl: walks addi, lw, sw, then each halt cause and a mid-MEM reset.
module tb_npc_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_gnt = 1'b0;
  logic        ifu_rvalid = 1'b0;
  logic [31:0] ifu_rdata = '0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] dec_dnpc = '0;
  logic [2:0]  dec_load = '0;
  logic [3:0]  dec_store = '0;
  logic        dec_regW = 1'b0;
  logic        dec_ebreak = 1'b0;
  logic        dec_inv = 1'b0;
  logic        lsu_req;
  logic        lsu_done = 1'b0;
  logic        wb_en;
  logic        retire;
  logic [63:0] instret;
  logic        halt;
  logic [1:0]  halt_code;

  int checks = 0;
  int errors = 0;

  npc_seq_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(8), .INSTRET_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .pc(pc), .inst(inst),
    .dec_dnpc(dec_dnpc), .dec_load(dec_load), .dec_store(dec_store),
    .dec_regW(dec_regW), .dec_ebreak(dec_ebreak), .dec_inv(dec_inv),
    .lsu_req(lsu_req), .lsu_done(lsu_done),
    .wb_en(wb_en), .retire(retire), .instret(instret),
    .halt(halt), .halt_code(halt_code)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Asynchronous reset pulse, then release and step into FETCH.
  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_pc", pc, RST_PC);
    checkOutput("rst_inst", inst, 32'h0000_0013);
    checkOutput("rst_instret", instret, 0);
    checkOutput("rst_halt", {halt_code, halt}, 0);
    checkOutput("rst_reqs", {ifu_req, lsu_req, wb_en, retire}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_no_req", ifu_req, 0);
    @(negedge clk);
    checkOutput("fetch_req", ifu_req, 1);
    checkOutput("fetch_addr", ifu_addr, RST_PC);
  endtask

  // Zero-wait fetch from FETCH; returns at the negedge inside DECODE.
  task automatic applyStimulus(input logic [31:0] word, input logic [31:0] dnpc, input logic [2:0] ld,
                               input logic [3:0] st, input logic regw, input logic ebk, input logic inv);
    ifu_gnt    = 1'b1;
    ifu_rvalid = 1'b1;
    ifu_rdata  = word;
    dec_dnpc   = dnpc;
    dec_load   = ld;
    dec_store  = st;
    dec_regW   = regw;
    dec_ebreak = ebk;
    dec_inv    = inv;
    @(negedge clk);
    ifu_gnt    = 1'b0;
    ifu_rvalid = 1'b0;
    checkOutput("decode_inst", inst, {32'h0, word});
    checkOutput("decode_no_req", ifu_req, 0);
  endtask

  initial begin
    int cnt;
    logic seen;
    #2;
    applyReset();

    // addi x1,x0,5: FETCH, DECODE, WB
    applyStimulus(32'h0050_0093, 32'h8000_0004, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("addi_no_wb_in_decode", wb_en, 0);
    @(negedge clk);
    checkOutput("addi_wb_en", wb_en, 1);
    checkOutput("addi_retire", retire, 1);
    checkOutput("addi_pc_in_wb", pc, RST_PC);
    @(negedge clk);
    checkOutput("addi_pc", pc, 32'h8000_0004);
    checkOutput("addi_instret", instret, 1);
    checkOutput("addi_pulse_end", {wb_en, retire}, 0);
    checkOutput("addi_refetch", ifu_req, 1);

    // lw x2,0(x1): rvalid two cycles after gnt, lsu_done three cycles after lsu_req
    ifu_gnt = 1'b1;
    @(negedge clk);
    ifu_gnt = 1'b0;
    checkOutput("lw_fwait_req_low", ifu_req, 0);
    @(negedge clk);
    ifu_rvalid = 1'b1;
    ifu_rdata  = 32'h0000_a103;
    dec_dnpc   = 32'h8000_0008;
    dec_load   = 3'd2;
    dec_regW   = 1'b1;
    @(negedge clk);
    ifu_rvalid = 1'b0;
    checkOutput("lw_inst", inst, 32'h0000_a103);
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (lsu_req) cnt++;
      if (i == 2) lsu_done = 1'b1;
      @(negedge clk);
    end
    lsu_done = 1'b0;
    checkOutput("lw_lsu_req_cycles", cnt, 3);
    checkOutput("lw_lsu_req_drop", lsu_req, 0);
    checkOutput("lw_wb_en", wb_en, 1);
    checkOutput("lw_retire", retire, 1);
    @(negedge clk);
    checkOutput("lw_pc", pc, 32'h8000_0008);
    checkOutput("lw_instret", instret, 2);

    // sw x2,0(x1): store commits, retires without a register write
    applyStimulus(32'h0020_a023, 32'h8000_000c, 3'd0, 4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sw_lsu_req", lsu_req, 1);
    lsu_done = 1'b1;
    @(negedge clk);
    lsu_done = 1'b0;
    checkOutput("sw_lsu_drop", lsu_req, 0);
    checkOutput("sw_wb_en", wb_en, 0);
    checkOutput("sw_retire", retire, 1);
    @(negedge clk);
    checkOutput("sw_pc", pc, 32'h8000_000c);
    checkOutput("sw_instret", instret, 3);

    // ebreak halts without retiring or moving pc
    applyStimulus(32'h0010_0073, 32'h8000_0010, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("ebk_halt", halt, 1);
    checkOutput("ebk_code", halt_code, 1);
    checkOutput("ebk_pc", pc, 32'h8000_000c);
    checkOutput("ebk_instret", instret, 3);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | ifu_req | retire | wb_en | lsu_req;
      @(negedge clk);
    end
    checkOutput("ebk_quiet", seen, 0);
    checkOutput("ebk_sticky", {halt_code, halt}, 3'b011);
    dec_ebreak = 1'b0;

    // illegal encoding
    applyReset();
    applyStimulus(32'hffff_ffff, 32'h8000_0004, 3'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("inv_halt", {halt_code, halt}, 3'b101);
    checkOutput("inv_pc", pc, RST_PC);
    checkOutput("inv_no_wb", {wb_en, retire}, 0);
    dec_inv = 1'b0;

    // misaligned next PC
    applyReset();
    applyStimulus(32'h0020_006f, 32'h8000_0002, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("mis_halt", {halt_code, halt}, 3'b101);
    checkOutput("mis_instret", instret, 0);

    // memory timeout: lsu_done never arrives, TIMEOUT=8
    applyReset();
    applyStimulus(32'h0000_a103, 32'h8000_0004, 3'd2, 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (halt) break;
      if (lsu_req) cnt++;
      @(negedge clk);
    end
    checkOutput("tmo_mem_cycles", cnt, 8);
    checkOutput("tmo_halt", {halt_code, halt}, 3'b111);
    checkOutput("tmo_lsu_drop", lsu_req, 0);
    checkOutput("tmo_no_retire", instret, 0);

    // reset pulsed mid-MEM drops lsu_req at once and restarts from IDLE
    applyReset();
    applyStimulus(32'h0000_a103, 32'h8000_0004, 3'd2, 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_lsu_req", lsu_req, 1);
    #2;
    applyReset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
